// File: rtl/mo_mul_arbiter.sv
// Round-robin arbiter that time-shares one fully pipelined mo_mul among N_REQ requesters.
// Each issued operand pair carries a requester tag down a delay line so its product is steered back.
module mo_mul_arbiter #(
    parameter int N_REQ      = 4,
    parameter int MUL_LAT    = 8,
    parameter int DATA_WIDTH = 32,
    localparam int TAG_W     = $clog2(N_REQ),
    localparam int CNT_W     = $clog2(MUL_LAT + 2)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_a,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_b,
    output logic [DATA_WIDTH-1:0]         mul_a,
    output logic [DATA_WIDTH-1:0]         mul_b,
    input  logic [DATA_WIDTH-1:0]         mul_result,
    output logic [N_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [CNT_W-1:0]              inflight,
    output logic                          busy
);
    // Stage k of the tag pipe holds the issue made k+1 edges ago; the last stage lines up
    // with the cycle in which mo_mul presents that product, so it is captured on the next edge.
    localparam int LAST = MUL_LAT;

    logic [DATA_WIDTH-1:0] opa_arr [N_REQ];
    logic [DATA_WIDTH-1:0] opb_arr [N_REQ];

    logic [TAG_W-1:0]      rr_ptr_reg;
    logic [DATA_WIDTH-1:0] mul_a_reg, mul_b_reg;
    logic [LAST:0]         tag_vld_reg;
    logic [TAG_W-1:0]      tag_idx_reg [LAST+1];
    logic [N_REQ-1:0]      rsp_valid_reg;
    logic [DATA_WIDTH-1:0] rsp_data_reg;
    logic [CNT_W-1:0]      inflight_reg;

    logic                  grant_valid;
    logic [TAG_W-1:0]      grant_idx;
    logic [TAG_W-1:0]      cand;
    int                    j;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign opa_arr[gi]   = req_a[gi*DATA_WIDTH +: DATA_WIDTH];
            assign opb_arr[gi]   = req_b[gi*DATA_WIDTH +: DATA_WIDTH];
            assign req_ready[gi] = grant_valid && (grant_idx == TAG_W'(gi));
        end
    endgenerate

    // First asserted request found scanning upward from rr_ptr, wrapping at N_REQ.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        j           = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(rr_ptr_reg) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            cand = TAG_W'(j);
            if (!grant_valid && req_valid[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg    <= '0;
            mul_a_reg     <= '0;
            mul_b_reg     <= '0;
            tag_vld_reg   <= '0;
            for (int k = 0; k <= LAST; k++) begin
                tag_idx_reg[k] <= '0;
            end
            rsp_valid_reg <= '0;
            rsp_data_reg  <= '0;
            inflight_reg  <= '0;
        end else begin
            if (grant_valid) begin
                mul_a_reg  <= opa_arr[grant_idx];
                mul_b_reg  <= opb_arr[grant_idx];
                rr_ptr_reg <= (grant_idx == TAG_W'(N_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
            end

            tag_vld_reg    <= {tag_vld_reg[LAST-1:0], grant_valid};
            tag_idx_reg[0] <= grant_idx;
            for (int k = 1; k <= LAST; k++) begin
                tag_idx_reg[k] <= tag_idx_reg[k-1];
            end

            if (tag_vld_reg[LAST]) begin
                rsp_valid_reg <= N_REQ'(1) << tag_idx_reg[LAST];
                rsp_data_reg  <= mul_result;
            end else begin
                rsp_valid_reg <= '0;
            end

            // An issue and a return on the same edge cancel out.
            if (grant_valid && !tag_vld_reg[LAST]) begin
                inflight_reg <= inflight_reg + CNT_W'(1);
            end else if (!grant_valid && tag_vld_reg[LAST]) begin
                inflight_reg <= inflight_reg - CNT_W'(1);
            end
        end
    end

    assign mul_a     = mul_a_reg;
    assign mul_b     = mul_b_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign inflight  = inflight_reg;
    assign busy      = (inflight_reg != '0);

endmodule
